vsa_multicycle_param: RTL and testbench



---
 rtl/vsa_multicycle_param.sv | 178 +++++++++++++++++
 tb/tb_vsa_multicycle_param.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsa_multicycle_param.sv
// rtl/vsa_multicycle_param.sv - parametrised multicycle VSA core with fetch/memory handshakes and HALT
//
// Purpose: non-pipelined five-stage (IF/ID/EX/MEM/WB) CPU sitting between the
// instruction cache and the data cache.
// Ports:
//   clock        master clock, all state on rising edge
//   reset        asynchronous active-high clear of all state
//   pc           registered instruction address
//   instruction  instruction word, accepted in IF when instr_valid=1
//   instr_valid  instruction word valid
//   alu_output   ALU result / data address register
//   datain       load data, captured on mem_ack during a load
//   dataout      store data (operand register B)
//   rd, wr       data read / write requests, held through the MEM handshake
//   mem_ack      data access complete
//   halted       core is in HLT
//   state        current control state
module vsa_multicycle_param #(
    parameter int DW  = 5,
    parameter int RB  = 2,
    parameter int PCW = 5,
    localparam int IW = 3 * RB + 6,
    localparam int MW = RB + 3
) (
    input  logic           clock,
    input  logic           reset,
    output logic [PCW-1:0] pc,
    input  logic [IW-1:0]  instruction,
    input  logic           instr_valid,
    output logic [DW-1:0]  alu_output,
    input  logic [DW-1:0]  datain,
    output logic [DW-1:0]  dataout,
    output logic           rd,
    output logic           wr,
    input  logic           mem_ack,
    output logic           halted,
    output logic [2:0]     state
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;
    localparam logic [2:0] S_HLT = 3'd5;

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_BEQZ = 3'd2;
    localparam logic [2:0] OP_ALU  = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_SUBI = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    logic [PCW-1:0] npc;
    logic [IW-1:0]  ir;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [DW-1:0]  lmd;
    logic           cond;
    logic [DW-1:0]  regFile [0:2**RB-1];

    // Instruction fields; rt shares the rs2 slot and imm overlaps rd/fun.
    logic [2:0]           opcode;
    logic [RB-1:0]        rs1;
    logic [RB-1:0]        rs2;
    logic [RB-1:0]        rdIdx;
    logic [2:0]           fun;
    logic signed [MW-1:0] immS;
    logic [DW-1:0]        immExt;
    logic [PCW-1:0]       brTarget;
    logic [DW-1:0]        aluRes;
    logic                 memDone;

    assign opcode = ir[IW-1 -: 3];
    assign rs1    = ir[IW-4 -: RB];
    assign rs2    = ir[IW-4-RB -: RB];
    assign rdIdx  = ir[RB+2:3];
    assign fun    = ir[2:0];
    assign immS   = ir[MW-1:0];

    // Signed size casts sign-extend the immediate to the target width.
    assign immExt   = DW'(immS);
    assign brTarget = npc + (PCW'(immS) << 1);

    always_comb begin
        aluRes = '0;
        case (fun)
            3'd0: aluRes = a + b;
            3'd1: aluRes = a - b;
            3'd2: aluRes = a & b;
            3'd3: aluRes = a | b;
            3'd4: aluRes = a ^ b;
            3'd5: aluRes = ~a;
            3'd6: aluRes = a >> 1;
            3'd7: aluRes = $signed(a) >>> 1;
            default: aluRes = '0;
        endcase
    end

    // Only loads and stores wait for mem_ack; everything else spends one MEM cycle.
    assign memDone = (opcode == OP_LW || opcode == OP_SW) ? mem_ack : 1'b1;

    assign rd      = (state == S_MEM) && (opcode == OP_LW);
    assign wr      = (state == S_MEM) && (opcode == OP_SW);
    assign halted  = (state == S_HLT);
    assign dataout = b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IF;
            pc         <= '0;
            npc        <= '0;
            ir         <= '0;
            a          <= '0;
            b          <= '0;
            alu_output <= '0;
            cond       <= 1'b0;
            lmd        <= '0;
            for (int i = 0; i < 2**RB; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            case (state)
                S_IF: begin
                    if (instr_valid) begin
                        ir    <= instruction;
                        npc   <= pc + PCW'(2);
                        state <= S_ID;
                    end
                end
                S_ID: begin
                    a     <= regFile[rs1];
                    b     <= regFile[rs2];
                    state <= S_EX;
                end
                S_EX: begin
                    if (opcode == OP_HALT) begin
                        state <= S_HLT;
                    end else begin
                        state <= S_MEM;
                        case (opcode)
                            OP_LW, OP_SW, OP_ADDI: alu_output <= a + immExt;
                            OP_SUBI:               alu_output <= a - immExt;
                            OP_ALU:                alu_output <= aluRes;
                            OP_BEQZ: begin
                                alu_output <= DW'(brTarget);
                                cond       <= (a == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                S_MEM: begin
                    if (memDone) begin
                        if (opcode == OP_LW) begin
                            lmd <= datain;
                        end
                        pc    <= (opcode == OP_BEQZ && cond) ? PCW'(alu_output) : npc;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    case (opcode)
                        OP_ALU: if (rdIdx != '0) regFile[rdIdx] <= alu_output;
                        OP_ADDI, OP_SUBI: if (rs2 != '0) regFile[rs2] <= alu_output;
                        OP_LW: if (rs2 != '0) regFile[rs2] <= lmd;
                        default: ;
                    endcase
                    state <= S_IF;
                end
                S_HLT: state <= S_HLT;
                default: state <= S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_vsa_multicycle_param.sv
// tb/tb_vsa_multicycle_param.sv - directed and randomized bench for vsa_multicycle_param
module tb_vsa_multicycle_param;

    localparam int DW  = 5;
    localparam int RB  = 2;
    localparam int PCW = 5;
    localparam int IW  = 3 * RB + 6;
    localparam int MW  = RB + 3;
    localparam int NR  = 2**RB;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [PCW-1:0] pc;
    logic [IW-1:0]  instruction = '0;
    logic           instr_valid = 1'b0;
    logic [DW-1:0]  alu_output;
    logic [DW-1:0]  datain = '0;
    logic [DW-1:0]  dataout;
    logic           rd;
    logic           wr;
    logic           mem_ack = 1'b0;
    logic           halted;
    logic [2:0]     state;

    int checks = 0;
    int errors = 0;

    int mr [NR];
    int mpc;

    vsa_multicycle_param #(.DW(DW), .RB(RB), .PCW(PCW)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .alu_output  (alu_output),
        .datain      (datain),
        .dataout     (dataout),
        .rd          (rd),
        .wr          (wr),
        .mem_ack     (mem_ack),
        .halted      (halted),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v, input int w);
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction

    function automatic logic [IW-1:0] ifmt(input logic [2:0] op, input logic [RB-1:0] s1,
                                           input logic [RB-1:0] rt, input logic [MW-1:0] imm);
        return {op, s1, rt, imm};
    endfunction

    function automatic logic [IW-1:0] rfmt(input logic [2:0] f, input logic [RB-1:0] s1,
                                           input logic [RB-1:0] s2, input logic [RB-1:0] d);
        return {3'd3, s1, s2, d, f};
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            chk(tag, 32'(dut.regFile[i]), 32'(mr[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mr[i] = 0;
        mpc = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        instr_valid = 1'b0;
        mem_ack = 1'b0;
        @(negedge clock);
        model_reset();
        chk("rst_pc", 32'(pc), 32'(0));
        chk("rst_state", 32'(state), 32'(0));
        chk("rst_rdwr", 32'({rd, wr, halted}), 32'(0));
        chk("rst_alu", 32'(alu_output), 32'(0));
        check_regs("rst_reg");
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Runs one instruction from IF back to IF (or into HLT) and checks it against the model.
    task automatic exec_instr(input logic [IW-1:0] ins, input int ifWait, input int memWait,
                              input logic [DW-1:0] din);
        int op, s1, s2, dIdx, f, simm, a, b, npc, res, expAlu, expCyc;
        int cyc, memCnt, rdCnt, wrCnt;
        logic [DW-1:0] wbAlu;
        int m, pm;
        m = (1 << DW) - 1;
        pm = (1 << PCW) - 1;
        op = int'(ins[IW-1 -: 3]);
        s1 = int'(ins[IW-4 -: RB]);
        s2 = int'(ins[IW-4-RB -: RB]);
        dIdx = int'(ins[RB+2:3]);
        f = int'(ins[2:0]);
        simm = sx(int'(ins[MW-1:0]), MW);
        a = mr[s1];
        b = mr[s2];
        npc = (mpc + 2) & pm;
        wbAlu = '0;

        chk("fetch_state", 32'(state), 32'(0));
        chk("fetch_pc", 32'(pc), 32'(mpc));
        instr_valid = 1'b0;
        for (int i = 0; i < ifWait; i++) begin
            instruction = IW'($urandom);
            mem_ack = 1'($urandom);
            @(negedge clock);
        end
        instruction = ins;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        instruction = IW'($urandom);

        cyc = 1; memCnt = 0; rdCnt = 0; wrCnt = 0;
        while (state != 3'd0 && state != 3'd5 && cyc < 40) begin
            datain = DW'($urandom);
            if (state == 3'd3) begin
                if (op == 0 || op == 1) begin
                    mem_ack = (memCnt >= memWait);
                    if (memCnt >= memWait) datain = din;
                end else begin
                    mem_ack = 1'($urandom);
                end
                memCnt++;
                if (rd) rdCnt++;
                if (wr) wrCnt++;
                if (op == 1) chk("sw_data", 32'(dataout), 32'(b));
            end else begin
                mem_ack = 1'($urandom);
                if (rd || wr) chk("rdwr_outside_mem", 32'({rd, wr}), 32'(0));
            end
            if (state == 3'd4) wbAlu = alu_output;
            @(negedge clock);
            cyc++;
        end
        mem_ack = 1'b0;

        expAlu = -1;
        case (op)
            0: begin expAlu = (a + simm) & m; if (s2 != 0) mr[s2] = int'(din); end
            1: expAlu = (a + simm) & m;
            2: expAlu = (npc + 2 * simm) & pm;
            3: begin
                case (f)
                    0: res = a + b;
                    1: res = a - b;
                    2: res = a & b;
                    3: res = a | b;
                    4: res = a ^ b;
                    5: res = ~a;
                    6: res = a >> 1;
                    default: res = sx(a, DW) >>> 1;
                endcase
                expAlu = res & m;
                if (dIdx != 0) mr[dIdx] = expAlu;
            end
            4: begin expAlu = (a + simm) & m; if (s2 != 0) mr[s2] = expAlu; end
            5: begin expAlu = (a - simm) & m; if (s2 != 0) mr[s2] = expAlu; end
            default: ;
        endcase
        if (op == 2 && a == 0) mpc = expAlu;
        else if (op != 6) mpc = npc;

        expCyc = (op == 6) ? 3 : ((op == 0 || op == 1) ? 5 + memWait : 5);
        chk("cycles", 32'(cyc), 32'(expCyc));
        chk("rd_cycles", 32'(rdCnt), 32'((op == 0) ? memWait + 1 : 0));
        chk("wr_cycles", 32'(wrCnt), 32'((op == 1) ? memWait + 1 : 0));
        if (expAlu >= 0) chk("wb_alu", 32'(wbAlu), 32'(expAlu));
        check_regs("reg");
    endtask

    initial begin
        logic [IW-1:0] ins;
        logic [PCW-1:0] pcFrozen;
        model_reset();
        #1;
        chk("async_rst_state", 32'(state), 32'(0));
        do_reset();

        // SUB of a register with itself
        exec_instr(ifmt(3'd4, 2'd0, 2'd1, 5'd7), 0, 0, '0);
        exec_instr(ifmt(3'd4, 2'd0, 2'd2, 5'd5), 1, 0, '0);
        exec_instr(rfmt(3'd1, 2'd1, 2'd1, 2'd2), 0, 0, '0);
        chk("sub_same_r2", 32'(dut.regFile[2]), 32'(0));

        // ADDI with negative immediate
        exec_instr(ifmt(3'd4, 2'd0, 2'd1, 5'd3), 2, 0, '0);
        exec_instr(ifmt(3'd4, 2'd1, 2'd2, 5'b11110), 0, 0, '0);
        chk("addi_neg_r2", 32'(dut.regFile[2]), 32'(1));

        // LW with three wait cycles
        exec_instr(ifmt(3'd0, 2'd1, 2'd3, 5'd2), 0, 3, 5'h15);
        chk("lw_r3", 32'(dut.regFile[3]), 32'h15);

        // write to R0 is dropped
        exec_instr(ifmt(3'd4, 2'd1, 2'd0, 5'd4), 0, 0, '0);
        chk("r0_zero", 32'(dut.regFile[0]), 32'(0));

        // BEQZ taken from pc=4
        do_reset();
        exec_instr(ifmt(3'd7, 2'd0, 2'd0, 5'd0), 0, 0, '0);
        exec_instr(ifmt(3'd7, 2'd0, 2'd0, 5'd0), 0, 0, '0);
        exec_instr(ifmt(3'd2, 2'd0, 2'd0, 5'd3), 0, 0, '0);
        chk("beqz_taken_pc", 32'(pc), 32'(12));

        // BEQZ not taken from pc=4, then wrap from pc=30
        do_reset();
        exec_instr(ifmt(3'd4, 2'd0, 2'd1, 5'd1), 0, 0, '0);
        exec_instr(ifmt(3'd7, 2'd0, 2'd0, 5'd0), 0, 0, '0);
        exec_instr(ifmt(3'd2, 2'd1, 2'd0, 5'd3), 0, 0, '0);
        chk("beqz_not_taken_pc", 32'(pc), 32'(6));
        exec_instr(ifmt(3'd2, 2'd0, 2'd0, 5'd11), 0, 0, '0);
        chk("beqz_to_30", 32'(pc), 32'(30));
        exec_instr(ifmt(3'd2, 2'd1, 2'd0, 5'd5), 0, 0, '0);
        chk("pc_wrap", 32'(pc), 32'(0));

        // random instruction stream, HALT excluded
        for (int n = 0; n < 60; n++) begin
            ins = IW'($urandom);
            if (ins[IW-1 -: 3] == 3'd6) ins[IW-1 -: 3] = 3'd7;
            exec_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), DW'($urandom));
        end

        // reset during a stalled SW
        exec_instr(ifmt(3'd4, 2'd0, 2'd2, 5'd9), 0, 0, '0);
        instruction = ifmt(3'd1, 2'd0, 2'd2, 5'd1);
        instr_valid = 1'b1;
        mem_ack = 1'b0;
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        chk("sw_wait_wr", 32'({state, wr}), 32'({3'd3, 1'b1}));
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("midrst_wr", 32'(wr), 32'(0));
        chk("midrst_state", 32'(state), 32'(0));
        chk("midrst_pc", 32'(pc), 32'(0));
        check_regs("midrst_reg");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        exec_instr(ifmt(3'd7, 2'd0, 2'd0, 5'd0), 0, 0, '0);

        // HALT freezes the core
        exec_instr(ifmt(3'd4, 2'd0, 2'd3, 5'd6), 0, 0, '0);
        exec_instr(ifmt(3'd6, 2'd0, 2'd0, 5'd0), 0, 0, '0);
        chk("halted", 32'(halted), 32'(1));
        pcFrozen = pc;
        for (int i = 0; i < 25; i++) begin
            instr_valid = 1'($urandom);
            instruction = IW'($urandom);
            mem_ack = 1'($urandom);
            @(negedge clock);
            chk("hlt_pc", 32'(pc), 32'(pcFrozen));
            chk("hlt_flags", 32'({halted, rd, wr}), 32'(3'b100));
        end
        chk("hlt_state", 32'(state), 32'(5));
        check_regs("hlt_reg");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
